fifo_prio_split: RTL

FIFO_PRIO_SPLIT -- requirements
Module: fifo_prio_split

---
 rtl/fifo_prio_split.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fifo_prio_split.sv
// Two-class FIFO: writes are steered by wr_prio into independent HP/LP circular
// queues, each read on its own port with registered, 1-cycle-latency data.

module fifo_prio_split_q #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ovf_evt,
    output logic                  udf_evt
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  wr_ok, rd_ok;

    // Status comes from start-of-cycle pointers only, so a same-cycle read never
    // frees room for a write and a same-cycle write never feeds a read.
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                  (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
        count   = wr_ptr_q - rd_ptr_q;
        wr_ok   = wr_en && !full;
        rd_ok   = rd_en && !empty;
        ovf_evt = wr_en && full;
        udf_evt = rd_en && empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            dout_d   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= din;
    end

    assign dout = dout_q;
endmodule

module fifo_prio_split #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  wr_prio,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  hp_rd_en,
    output logic [DATA_WIDTH-1:0] hp_dout,
    input  logic                  lp_rd_en,
    output logic [DATA_WIDTH-1:0] lp_dout,
    output logic                  hp_empty,
    output logic                  hp_full,
    output logic                  lp_empty,
    output logic                  lp_full,
    output logic [ADDR_WIDTH:0]   hp_count,
    output logic [ADDR_WIDTH:0]   lp_count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int HP = 1;
    localparam int LP = 0;

    logic [1:0]                 q_wr, q_rd, q_empty, q_full, q_ovf, q_udf;
    logic [1:0][DATA_WIDTH-1:0] q_dout;
    logic [1:0][ADDR_WIDTH:0]   q_count;
    logic                       overflow_q, overflow_d;
    logic                       underflow_q, underflow_d;

    assign q_wr = {wr_en && wr_prio, wr_en && !wr_prio};
    assign q_rd = {hp_rd_en, lp_rd_en};

    for (genvar i = 0; i < 2; i++) begin : g_q
        fifo_prio_split_q #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_q (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (q_wr[i]),
            .din    (din),
            .rd_en  (q_rd[i]),
            .dout   (q_dout[i]),
            .empty  (q_empty[i]),
            .full   (q_full[i]),
            .count  (q_count[i]),
            .ovf_evt(q_ovf[i]),
            .udf_evt(q_udf[i])
        );
    end

    always_comb begin
        overflow_d  = overflow_q || (|q_ovf);
        underflow_d = underflow_q || (|q_udf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign hp_dout   = q_dout[HP];
    assign lp_dout   = q_dout[LP];
    assign hp_empty  = q_empty[HP];
    assign hp_full   = q_full[HP];
    assign lp_empty  = q_empty[LP];
    assign lp_full   = q_full[LP];
    assign hp_count  = q_count[HP];
    assign lp_count  = q_count[LP];
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule
